// File: rtl/elev_pkg.sv
// -----------------------------------------------------------------------------
// elev_pkg
// Shared types and constants for the elevator request scheduler.
//   FLOOR_W       : width of a floor number
//   NFLOORS       : number of floors served (one request bit per floor)
//   sched_state_t : scheduler top-level state
//   floor_t       : floor number type
// -----------------------------------------------------------------------------
package elev_pkg;

    localparam int FLOOR_W = 2;
    localparam int NFLOORS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } sched_state_t;

    typedef logic [FLOOR_W-1:0] floor_t;

endpackage

// File: rtl/elev_target_sel.sv
// -----------------------------------------------------------------------------
// elev_target_sel
// Combinational SCAN target picker. Finds the nearest pending floor above and
// below the current floor, then keeps the current direction if there is work
// ahead, otherwise reverses and takes the nearest floor the other way.
// The current floor itself is never offered as a target.
//
// Ports:
//   pending [NFLOORS-1:0] in  : latched, unserved requests
//   cf      [FLOOR_W-1:0] in  : current floor
//   dir_up                in  : current travel direction, 1 = up
//   target  [FLOOR_W-1:0] out : selected floor (equals cf when nothing found)
//   found                 out : a floor other than cf is pending
//   new_dir               out : direction implied by the selection
// -----------------------------------------------------------------------------
module elev_target_sel
    import elev_pkg::*;
(
    input  logic [NFLOORS-1:0] pending,
    input  floor_t             cf,
    input  logic               dir_up,
    output floor_t             target,
    output logic               found,
    output logic               new_dir
);

    floor_t near_above;
    floor_t near_below;
    logic   has_above;
    logic   has_below;

    always_comb begin
        near_above = '0;
        has_above  = 1'b0;
        // Walk downwards so the last hit is the lowest floor above cf.
        for (int i = NFLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(cf))) begin
                near_above = floor_t'(i);
                has_above  = 1'b1;
            end
        end

        near_below = '0;
        has_below  = 1'b0;
        // Walk upwards so the last hit is the highest floor below cf.
        for (int i = 0; i < NFLOORS; i++) begin
            if (pending[i] && (i < int'(cf))) begin
                near_below = floor_t'(i);
                has_below  = 1'b1;
            end
        end
    end

    always_comb begin
        target  = cf;
        found   = has_above | has_below;
        new_dir = dir_up;
        if (dir_up && has_above) begin
            target = near_above;
        end else if (!dir_up && has_below) begin
            target = near_below;
        end else if (has_above) begin
            // Was heading down with nothing below: turn around.
            new_dir = 1'b1;
            target  = near_above;
        end else if (has_below) begin
            // Was heading up with nothing above: turn around.
            new_dir = 1'b0;
            target  = near_below;
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_scheduler
// Latches hall/car calls for four floors, chooses the next target with a SCAN
// policy, drives it to the floor-tracking fsm and runs the door timer when the
// fsm reports arrival.
//
// Parameters:
//   DOOR_CYCLES : cycles door_open stays high per stop (1..15)
//   CNT_W       : door timer width, must hold DOOR_CYCLES
//
// Ports:
//   clk        in  : system clock, rising edge
//   rst        in  : synchronous active-high reset
//   req  [3:0] in  : call request per floor, pulse or level
//   cf   [1:0] in  : current floor reported by the fsm
//   floor[1:0] out : target floor driven to the fsm (holds when not valid)
//   tgt_valid  out : floor is a live target, fsm moves only while high
//   door_open  out : door open at cf
//   dir_up     out : current SCAN direction, 1 = up
//   pending[3:0] out : latched, unserved requests
//   busy       out : scheduler is not idle
// -----------------------------------------------------------------------------
module elevator_scheduler
    import elev_pkg::*;
#(
    parameter int DOOR_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NFLOORS-1:0] req,
    input  logic [FLOOR_W-1:0] cf,
    output logic [FLOOR_W-1:0] floor,
    output logic               tgt_valid,
    output logic               door_open,
    output logic               dir_up,
    output logic [NFLOORS-1:0] pending,
    output logic               busy
);

    localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES);

    sched_state_t       state_q,      state_d;
    logic [NFLOORS-1:0] pending_q,    pending_d;
    logic [CNT_W-1:0]   timer_q,      timer_d;
    floor_t             floor_q,      floor_d;
    logic               tgt_valid_q,  tgt_valid_d;
    logic               dir_up_q,     dir_up_d;
    floor_t             door_floor_q, door_floor_d;

    logic [NFLOORS-1:0] clear_mask;
    floor_t             sel_target;
    logic               sel_found;
    logic               sel_new_dir;

    elev_target_sel u_target_sel (
        .pending (pending_q),
        .cf      (cf),
        .dir_up  (dir_up_q),
        .target  (sel_target),
        .found   (sel_found),
        .new_dir (sel_new_dir)
    );

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        floor_d      = floor_q;
        tgt_valid_d  = tgt_valid_q;
        dir_up_d     = dir_up_q;
        door_floor_d = door_floor_q;
        clear_mask   = '0;

        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    if (pending_q[cf]) begin
                        // Call at the floor we are parked on: open directly.
                        state_d        = DOOR;
                        timer_d        = DOOR_LOAD;
                        door_floor_d   = cf;
                        clear_mask[cf] = 1'b1;
                    end else if (sel_found) begin
                        state_d     = MOVE;
                        floor_d     = sel_target;
                        dir_up_d    = sel_new_dir;
                        tgt_valid_d = 1'b1;
                    end
                end
            end

            MOVE: begin
                if (cf == floor_q) begin
                    state_d        = DOOR;
                    tgt_valid_d    = 1'b0;
                    timer_d        = DOOR_LOAD;
                    door_floor_d   = cf;
                    clear_mask[cf] = 1'b1;
                end else if (sel_found && (sel_new_dir == dir_up_q)) begin
                    // The current target is still pending and ahead of cf, so
                    // the nearest floor ahead is either it or an en-route stop
                    // between cf and it; never a floor behind.
                    floor_d = sel_target;
                end
            end

            DOOR: begin
                // Calls for the floor the door is open at are absorbed. The
                // floor latched on entry is used so a cf glitch from the fsm
                // neither clears another floor nor disturbs the timing.
                clear_mask[door_floor_q] = 1'b1;
                if (timer_q != '0) begin
                    timer_d = timer_q - CNT_W'(1);
                end
                if (timer_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        pending_d = (pending_q | req) & ~clear_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            timer_q      <= '0;
            floor_q      <= '0;
            tgt_valid_q  <= 1'b0;
            dir_up_q     <= 1'b1;
            door_floor_q <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            timer_q      <= timer_d;
            floor_q      <= floor_d;
            tgt_valid_q  <= tgt_valid_d;
            dir_up_q     <= dir_up_d;
            door_floor_q <= door_floor_d;
        end
    end

    assign floor     = floor_q;
    assign tgt_valid = tgt_valid_q;
    assign door_open = (state_q == DOOR) && (timer_q != '0);
    assign dir_up    = dir_up_q;
    assign pending   = pending_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_elevator_scheduler.sv
module tb_elevator_scheduler;

    localparam int DC     = 4;
    localparam int TRAVEL = 3;   // cycles the fsm takes per floor

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [1:0] cf;
    logic [1:0] floor;
    logic       tgt_valid;
    logic       door_open;
    logic       dir_up;
    logic [3:0] pending;
    logic       busy;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    elevator_scheduler #(.DOOR_CYCLES(DC), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .cf        (cf),
        .floor     (floor),
        .tgt_valid (tgt_valid),
        .door_open (door_open),
        .dir_up    (dir_up),
        .pending   (pending),
        .busy      (busy)
    );

    // Reference model: mode 0 = waiting, 1 = travelling, 2 = door open
    int     m_mode;
    bit [3:0] m_pend;
    int     m_floor;
    bit     m_tv;
    bit     m_dir;
    int     m_timer;
    int     m_door_floor;
    int     move_cnt;

    function automatic int nearest(bit [3:0] p, int c, bit up);
        if (up) begin
            for (int f = c + 1; f < 4; f++) if (p[f]) return f;
        end else begin
            for (int f = c - 1; f >= 0; f--) if (p[f]) return f;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pend = 4'b0; m_floor = 0; m_tv = 0;
        m_dir = 1; m_timer = 0; m_door_floor = 0;
    endtask

    task automatic model_step(input bit r_rst, input bit [3:0] r_req, input int c);
        bit [3:0] nxt;
        int t;
        if (r_rst) begin
            model_reset();
            return;
        end
        nxt = m_pend | r_req;
        if (m_mode == 0) begin
            if (m_pend != 0) begin
                if (m_pend[c]) begin
                    m_mode = 2; m_timer = DC; m_door_floor = c; nxt[c] = 1'b0;
                end else begin
                    t = nearest(m_pend, c, m_dir);
                    if (t < 0) begin
                        m_dir = !m_dir;
                        t = nearest(m_pend, c, m_dir);
                    end
                    m_floor = t; m_tv = 1; m_mode = 1;
                end
            end
        end else if (m_mode == 1) begin
            if (c == m_floor) begin
                m_mode = 2; m_tv = 0; m_timer = DC; m_door_floor = c; nxt[c] = 1'b0;
            end else begin
                t = nearest(m_pend, c, m_dir);
                if (t >= 0) m_floor = t;
            end
        end else begin
            nxt[m_door_floor] = 1'b0;
            if (m_timer <= 1) m_mode = 0;
            if (m_timer > 0) m_timer--;
        end
        m_pend = nxt;
    endtask

    // One clock: drive inputs, advance the model, then let the fsm stand-in
    // step cf one floor every TRAVEL cycles while a target is live.
    task automatic tick(input logic [3:0] r, input logic rs);
        bit tv_prev;
        int fl_prev;
        req = r;
        rst = rs;
        tv_prev = m_tv;
        fl_prev = m_floor;
        @(posedge clk);
        model_step(rs, r, int'(cf));
        #1;
        if (tv_prev && (int'(cf) != fl_prev)) begin
            move_cnt++;
            if (move_cnt == TRAVEL) begin
                move_cnt = 0;
                cf = (fl_prev > int'(cf)) ? cf + 2'd1 : cf - 2'd1;
            end
        end else begin
            move_cnt = 0;
        end
    endtask

    // Idle the request lines until one door period has opened and closed.
    task automatic serve(output int arrive_cf, output int door_len,
                         output bit pend_at_door, output bit tv_at_door,
                         output bit timeout);
        int n;
        n = 0; timeout = 0; door_len = 0; arrive_cf = -1;
        pend_at_door = 0; tv_at_door = 0;
        while (door_open !== 1'b1 && n < 200) begin
            tick(4'b0000, 1'b0);
            n++;
        end
        if (n >= 200) begin
            timeout = 1;
            return;
        end
        arrive_cf = int'(cf);
        pend_at_door = pending[cf];
        tv_at_door = tgt_valid;
        while (door_open === 1'b1 && n < 400) begin
            door_len++;
            tick(4'b0000, 1'b0);
            n++;
        end
        if (n >= 400) timeout = 1;
    endtask

    task automatic test_reset();
        tick(4'b1111, 1'b1);
        tick(4'b1111, 1'b1);
        ntests++; if (floor !== 2'd0) begin nfail++; $display("FAIL reset_floor: got %0d, expected 0", floor); end
        ntests++; if (tgt_valid !== 1'b0) begin nfail++; $display("FAIL reset_tgt_valid: got %0b, expected 0", tgt_valid); end
        ntests++; if (door_open !== 1'b0) begin nfail++; $display("FAIL reset_door_open: got %0b, expected 0", door_open); end
        ntests++; if (dir_up !== 1'b1) begin nfail++; $display("FAIL reset_dir_up: got %0b, expected 1", dir_up); end
        ntests++; if (pending !== 4'b0000) begin nfail++; $display("FAIL reset_pending: got %b, expected 0000", pending); end
        ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
        tick(4'b0000, 1'b0);
        ntests++; if (pending !== 4'b0000) begin nfail++; $display("FAIL reset_release_pending: got %b, expected 0000", pending); end
    endtask

    task automatic test_single_call();
        int a, d; bit pd, tv, to;
        tick(4'b1000, 1'b0);
        ntests++; if (pending !== 4'b1000) begin nfail++; $display("FAIL single_pending: got %b, expected 1000", pending); end
        ntests++; if (tgt_valid !== 1'b0) begin nfail++; $display("FAIL single_tv_early: got %0b, expected 0", tgt_valid); end
        tick(4'b0000, 1'b0);
        ntests++; if (tgt_valid !== 1'b1) begin nfail++; $display("FAIL single_tv: got %0b, expected 1", tgt_valid); end
        ntests++; if (floor !== 2'd3) begin nfail++; $display("FAIL single_floor: got %0d, expected 3", floor); end
        serve(a, d, pd, tv, to);
        ntests++; if (to) begin nfail++; $display("FAIL single_timeout: got timeout, expected door period"); end
        ntests++; if (a != 3) begin nfail++; $display("FAIL single_arrive: got cf %0d, expected 3", a); end
        ntests++; if (d != DC) begin nfail++; $display("FAIL single_door_len: got %0d, expected %0d", d, DC); end
        ntests++; if (pd !== 1'b0 || tv !== 1'b0) begin nfail++; $display("FAIL single_at_door: got pend %0b tv %0b, expected 0 0", pd, tv); end
        ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL single_busy_after: got %0b, expected 0", busy); end
    endtask

    task automatic test_en_route();
        int a, d, n; bit pd, tv, to;
        tick(4'b0001, 1'b0);
        serve(a, d, pd, tv, to);
        ntests++; if (to || a != 0) begin nfail++; $display("FAIL enroute_home: got cf %0d timeout %0b, expected 0 0", a, to); end
        tick(4'b1000, 1'b0);
        tick(4'b0000, 1'b0);
        ntests++; if (floor !== 2'd3 || dir_up !== 1'b1) begin nfail++; $display("FAIL enroute_start: got floor %0d dir %0b, expected 3 1", floor, dir_up); end
        n = 0;
        while (cf !== 2'd1 && n < 50) begin tick(4'b0000, 1'b0); n++; end
        ntests++; if (n >= 50) begin nfail++; $display("FAIL enroute_reach1: got cf %0d, expected 1", cf); end
        tick(4'b0100, 1'b0);
        tick(4'b0000, 1'b0);
        ntests++; if (floor !== 2'd2 || tgt_valid !== 1'b1) begin nfail++; $display("FAIL enroute_retarget: got floor %0d tv %0b, expected 2 1", floor, tgt_valid); end
        serve(a, d, pd, tv, to);
        ntests++; if (to || a != 2 || d != DC) begin nfail++; $display("FAIL enroute_stop2: got cf %0d len %0d, expected 2 %0d", a, d, DC); end
        tick(4'b0000, 1'b0);
        ntests++; if (floor !== 2'd3 || tgt_valid !== 1'b1) begin nfail++; $display("FAIL enroute_resume: got floor %0d tv %0b, expected 3 1", floor, tgt_valid); end
        serve(a, d, pd, tv, to);
        ntests++; if (to || a != 3) begin nfail++; $display("FAIL enroute_stop3: got cf %0d, expected 3", a); end
    endtask

    task automatic test_scan();
        int a, d; bit pd, tv, to;
        tick(4'b0001, 1'b0);
        serve(a, d, pd, tv, to);
        tick(4'b0010, 1'b0);
        serve(a, d, pd, tv, to);
        ntests++; if (to || a != 1 || dir_up !== 1'b1) begin nfail++; $display("FAIL scan_setup: got cf %0d dir %0b, expected 1 1", a, dir_up); end
        tick(4'b1001, 1'b0);
        ntests++; if (pending !== 4'b1001) begin nfail++; $display("FAIL scan_pending: got %b, expected 1001", pending); end
        tick(4'b0000, 1'b0);
        ntests++; if (floor !== 2'd3 || dir_up !== 1'b1) begin nfail++; $display("FAIL scan_first: got floor %0d dir %0b, expected 3 1", floor, dir_up); end
        serve(a, d, pd, tv, to);
        ntests++; if (to || a != 3) begin nfail++; $display("FAIL scan_serve3: got cf %0d, expected 3", a); end
        tick(4'b0000, 1'b0);
        ntests++; if (floor !== 2'd0 || dir_up !== 1'b0) begin nfail++; $display("FAIL scan_reverse: got floor %0d dir %0b, expected 0 0", floor, dir_up); end
        serve(a, d, pd, tv, to);
        ntests++; if (to || a != 0 || pending !== 4'b0000) begin nfail++; $display("FAIL scan_serve0: got cf %0d pending %b, expected 0 0000", a, pending); end
    endtask

    task automatic test_same_floor();
        int a, d, len, n; bit pd, tv, to, tv_seen;
        tick(4'b0100, 1'b0);
        serve(a, d, pd, tv, to);
        ntests++; if (to || a != 2) begin nfail++; $display("FAIL same_setup: got cf %0d, expected 2", a); end
        tick(4'b0100, 1'b0);
        ntests++; if (pending !== 4'b0100 || door_open !== 1'b0) begin nfail++; $display("FAIL same_latch: got pending %b door %0b, expected 0100 0", pending, door_open); end
        tick(4'b0000, 1'b0);
        ntests++; if (door_open !== 1'b1 || pending !== 4'b0000) begin nfail++; $display("FAIL same_open: got door %0b pending %b, expected 1 0000", door_open, pending); end
        len = 0; n = 0; tv_seen = 0;
        while (door_open === 1'b1 && n < 20) begin
            len++;
            if (tgt_valid !== 1'b0) tv_seen = 1;
            // a repeat call at the open floor on the second door cycle
            tick((len == 2) ? 4'b0100 : 4'b0000, 1'b0);
            n++;
        end
        ntests++; if (len != DC) begin nfail++; $display("FAIL same_door_len: got %0d, expected %0d", len, DC); end
        ntests++; if (tv_seen) begin nfail++; $display("FAIL same_no_tv: got tgt_valid 1, expected 0"); end
        ntests++; if (pending !== 4'b0000 || busy !== 1'b0) begin nfail++; $display("FAIL same_absorb: got pending %b busy %0b, expected 0000 0", pending, busy); end
    endtask

    task automatic test_rst_mid_move();
        int a, d; bit pd, tv, to;
        tick(4'b0001, 1'b0);
        serve(a, d, pd, tv, to);
        tick(4'b0110, 1'b0);
        tick(4'b0000, 1'b0);
        ntests++; if (tgt_valid !== 1'b1 || pending !== 4'b0110) begin nfail++; $display("FAIL rstmid_setup: got tv %0b pending %b, expected 1 0110", tgt_valid, pending); end
        tick(4'b1111, 1'b1);
        ntests++; if (tgt_valid !== 1'b0 || pending !== 4'b0000 || busy !== 1'b0 || floor !== 2'd0) begin
            nfail++; $display("FAIL rstmid_clear: got tv %0b pending %b busy %0b floor %0d, expected 0 0000 0 0", tgt_valid, pending, busy, floor);
        end
        tick(4'b0000, 1'b0);
        ntests++; if (pending !== 4'b0000 || busy !== 1'b0) begin nfail++; $display("FAIL rstmid_after: got pending %b busy %0b, expected 0000 0", pending, busy); end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       rs;
        for (int cyc = 0; cyc < 3000 && nfail < 30; cyc++) begin
            r  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rs = ($urandom_range(0, 399) == 0);
            tick(r, rs);
            ntests++; if (floor !== 2'(m_floor)) begin nfail++; $display("FAIL rand_floor cyc %0d: got %0d, expected %0d", cyc, floor, m_floor); end
            ntests++; if (tgt_valid !== m_tv) begin nfail++; $display("FAIL rand_tv cyc %0d: got %0b, expected %0b", cyc, tgt_valid, m_tv); end
            ntests++; if (door_open !== (m_mode == 2 && m_timer != 0)) begin nfail++; $display("FAIL rand_door cyc %0d: got %0b, expected %0b", cyc, door_open, (m_mode == 2 && m_timer != 0)); end
            ntests++; if (dir_up !== m_dir) begin nfail++; $display("FAIL rand_dir cyc %0d: got %0b, expected %0b", cyc, dir_up, m_dir); end
            ntests++; if (pending !== m_pend) begin nfail++; $display("FAIL rand_pending cyc %0d: got %b, expected %b", cyc, pending, m_pend); end
            ntests++; if (busy !== (m_mode != 0)) begin nfail++; $display("FAIL rand_busy cyc %0d: got %0b, expected %0b", cyc, busy, (m_mode != 0)); end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        cf  = 2'd0;
        move_cnt = 0;
        model_reset();
        test_reset();
        test_single_call();
        test_en_route();
        test_scan();
        test_same_floor();
        test_rst_mid_move();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", ntests);
        $fatal(1, "watchdog expired");
    end

endmodule
